// File: rtl/udp_pkg.sv
// Shared definitions for the UDP frame builder payload path.
package udp_pkg;

    localparam int PAYLOAD_LEN_W = 16;
    localparam int RNG_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND_HI,
        ST_SEND_LO
    } payload_state_t;

endpackage

// File: rtl/udp_payload_ctrl.sv
// Payload sequencer: fetches 16-bit RNG samples and streams them MSB byte first
// on a valid/ready byte stream of programmable length.
module udp_payload_ctrl
    import udp_pkg::*;
#(
    parameter int LEN_W = PAYLOAD_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    output logic             rng_enable,
    input  logic [RNG_W-1:0] rng_sample,
    input  logic             rng_valid,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    payload_state_t   state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [RNG_W-1:0] hold_q, hold_d;
    logic             done_q, done_d;
    logic             last_byte;

    // Byte counter saturates at zero so an oversized length can never wrap.
    function automatic logic [LEN_W-1:0] sat_dec(input logic [LEN_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    assign last_byte  = (remaining_q <= ONE);
    assign rng_enable = (state_q == ST_FETCH);
    assign m_tvalid   = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
    assign m_tlast    = m_tvalid && (remaining_q == ONE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    always_comb begin
        m_tdata = 8'h00;
        case (state_q)
            ST_SEND_HI: m_tdata = hold_q[RNG_W-1 -: 8];
            ST_SEND_LO: m_tdata = hold_q[7:0];
            default:    m_tdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (payload_len != '0) begin
                        remaining_d = payload_len;
                        state_d     = ST_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rng_valid) begin
                    hold_d  = rng_sample;
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (m_tready) begin
                    remaining_d = sat_dec(remaining_q);
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND_LO;
                    end
                end
            end
            ST_SEND_LO: begin
                if (m_tready) begin
                    remaining_d = sat_dec(remaining_q);
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_udp_payload_ctrl.sv
// Bench for udp_payload_ctrl paired with a behavioural RNG seeded at 0x0001.
module tb_udp_payload_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] payload_len;
    logic        rng_enable;
    logic [15:0] rng_sample;
    logic        rng_valid;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    udp_payload_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .payload_len(payload_len),
        .rng_enable(rng_enable), .rng_sample(rng_sample), .rng_valid(rng_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000);
    endfunction

    // Behavioural RNG: sample valid the cycle after enable; spurious valids with junk
    // data are injected outside WAIT when spur_en is set.
    logic [15:0] rng_state, rng_sq, junk;
    logic        rng_vq, spur, spur_en;

    always @(posedge clk) begin
        if (!rst_n) begin
            rng_state <= 16'h0001;
            rng_sq    <= 16'h0000;
            rng_vq    <= 1'b0;
        end else begin
            rng_vq <= rng_enable;
            if (rng_enable) begin
                rng_sq    <= rng_state;
                rng_state <= lfsr_next(rng_state);
            end
        end
    end

    assign rng_valid  = rng_vq | spur;
    assign rng_sample = spur ? junk : rng_sq;

    // Observation recorder
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         last_q[$];
    int en_cnt, done_cnt, vld_cnt, busy_cnt, stall_err;
    int first_en_cyc, first_vld_cyc, done_cyc, last_hs_cyc;
    logic       prev_stall;
    logic [7:0] prev_data;

    initial begin
        spur = 1'b0;
        junk = 16'h0;
        spur_en = 1'b0;
        prev_stall = 1'b0;
        prev_data = 8'h0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                if (m_tlast) last_q.push_back(got_q.size());
                got_q.push_back(m_tdata);
                last_hs_cyc = cyc;
            end
            if (m_tvalid) begin
                vld_cnt++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (rng_enable) begin
                en_cnt++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) stall_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end else begin
            prev_stall = 1'b0;
        end
        spur = spur_en && (rng_enable || m_tvalid) && ($urandom_range(0, 1) == 1);
        junk = 16'($urandom);
    end

    task automatic clear_mon();
        got_q.delete();
        last_q.delete();
        en_cnt = 0; done_cnt = 0; vld_cnt = 0; busy_cnt = 0; stall_err = 0;
        first_en_cyc = -1; first_vld_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; payload_len = 16'h0; m_tready = 1'b1; spur_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_mon();
    endtask

    // Reference: byte stream of a payload of len bytes, after skip samples were consumed.
    task automatic build_exp(input int len, input int skip);
        logic [15:0] s;
        s = 16'h0001;
        exp_q.delete();
        repeat (skip) s = lfsr_next(s);
        for (int i = 0; i < len; i++) begin
            if (i % 2 == 0) exp_q.push_back(s[15:8]);
            else begin
                exp_q.push_back(s[7:0]);
                s = lfsr_next(s);
            end
        end
    endtask

    task automatic run(input int len, input bit rnd, output int sc, output bit to);
        int n;
        payload_len = 16'(len);
        start = 1'b1;
        sc = cyc;
        tick();
        start = 1'b0;
        payload_len = 16'($urandom);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        m_tready = 1'b1;
        to = (done_cnt == 0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; payload_len = 16'h0; m_tready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rng_enable: got %b want 0", rng_enable); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        n_checks++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h want 00", m_tdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_payload(input string name, input int len, input bit rnd);
        int sc, lq;
        bit to;
        do_reset();
        spur_en = rnd;
        build_exp(len, 0);
        run(len, rnd, sc, to);
        spur_en = 1'b0;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no done within budget", name); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s_count: got %0d bytes want %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        lq = (last_q.size() == 1) ? last_q[0] : -1;
        n_checks++; if (lq != len - 1) begin n_fail++; $display("FAIL %s_tlast: got index %0d (marks %0d) want %0d", name, lq, last_q.size(), len - 1); end
        n_checks++; if (en_cnt != (len + 1) / 2) begin n_fail++; $display("FAIL %s_enables: got %0d want %0d", name, en_cnt, (len + 1) / 2); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
        n_checks++; if (first_en_cyc != sc + 1) begin n_fail++; $display("FAIL %s_enable_latency: got %0d want %0d", name, first_en_cyc - sc, 1); end
        n_checks++; if (first_vld_cyc != sc + 3) begin n_fail++; $display("FAIL %s_valid_latency: got %0d want %0d", name, first_vld_cyc - sc, 3); end
        n_checks++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL %s_done_timing: got %0d want %0d", name, done_cyc, last_hs_cyc + 1); end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL %s_stall_stability: got %0d violations want 0", name, stall_err); end
    endtask

    task automatic test_len6(); test_payload("len6", 6, 1'b0); endtask
    task automatic test_len3(); test_payload("len3", 3, 1'b0); endtask
    task automatic test_stall(); test_payload("stall4", 4, 1'b1); endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) test_payload($sformatf("rand%0d", k), $urandom_range(1, 24), 1'b1);
    endtask

    task automatic test_zero_len();
        int sc;
        bit to;
        do_reset();
        run(0, 1'b0, sc, to);
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc != sc + 1) begin n_fail++; $display("FAIL zero_done_timing: got %0d want %0d", done_cyc, sc + 1); end
        n_checks++; if (vld_cnt != 0) begin n_fail++; $display("FAIL zero_tvalid: got %0d cycles want 0", vld_cnt); end
        n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL zero_enables: got %0d want 0", en_cnt); end
        n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL zero_busy: got %0d cycles want 0", busy_cnt); end
    endtask

    task automatic test_start_ignored();
        int n;
        do_reset();
        build_exp(6, 0);
        payload_len = 16'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        payload_len = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 200) begin tick(); n++; end
        repeat (10) tick();
        n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL ignore_count: got %0d bytes want 6", got_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++; if (en_cnt != 3) begin n_fail++; $display("FAIL ignore_enables: got %0d want 3", en_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        payload_len = 16'd6; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 50) begin tick(); n++; end
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL midreset_setup: got %0d bytes want 2", got_q.size()); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m_tvalid); end
        n_checks++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL midreset_tdata: got %h want 00", m_tdata); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL midreset_tlast: got %b want 0", m_tlast); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_rng_enable: got %b want 0", rng_enable); end
        repeat (10) tick();
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL midreset_extra_bytes: got %0d want 2", got_q.size()); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int n, sc2, lq0, lq1;
        do_reset();
        build_exp(6, 0);
        payload_len = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin tick(); n++; end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        payload_len = 16'd4; start = 1'b1;
        sc2 = cyc;
        first_vld_cyc = -1;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt < 2 && n < 100) begin tick(); n++; end
        repeat (4) tick();
        n_checks++; if (first_vld_cyc != sc2 + 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", first_vld_cyc - sc2); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        n_checks++; if (en_cnt != 3) begin n_fail++; $display("FAIL b2b_enables: got %0d want 3", en_cnt); end
        n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        lq0 = (last_q.size() == 2) ? last_q[0] : -1;
        lq1 = (last_q.size() == 2) ? last_q[1] : -1;
        n_checks++; if (lq0 != 1 || lq1 != 5) begin n_fail++; $display("FAIL b2b_tlast: got %0d,%0d want 1,5", lq0, lq1); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; payload_len = 16'h0; m_tready = 1'b1;
        clear_mon();
        test_reset();
        test_len6();
        test_len3();
        test_zero_len();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
